// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, FIPS-197 S-box,
// and small per-length helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_RSV = 2'd3
  } key_len_e;

  // Index 0 is the leftmost byte, so SBOX[b] is S(b).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input key_len_e kl);
    logic [3:0] r;
    case (kl)
      KL_192:  r = 4'd6;
      KL_256:  r = 4'd8;
      default: r = 4'd4;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    logic [3:0] r;
    case (kl)
      KL_192:  r = 4'd12;
      KL_256:  r = 4'd14;
      default: r = 4'd10;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: S-box substitution on each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion (128/192/256) producing one word per clock
// into a word store, with a combinational round-key read port.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         ready,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  output logic [3:0]   nr,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int NWORDS = 4 * (MAX_KEY_BITS / 32 + 7);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  state_e     r_state,      w_state_nxt;
  logic [5:0] r_i,          w_i_nxt;
  logic [2:0] r_k,          w_k_nxt;
  logic [7:0] r_rcon,       w_rcon_nxt;
  key_len_e   r_key_len,    w_key_len_nxt;
  logic [3:0] r_nr,         w_nr_nxt;
  logic       r_keys_valid, w_keys_valid_nxt;
  logic       r_done,       w_done_nxt;
  logic       r_err,        w_err_nxt;
  logic       w_load, w_wr;

  logic [31:0] r_w [NWORDS];

  key_len_e    w_req_len;
  logic        w_len_ok;
  logic [3:0]  w_nk, w_nk_req;
  logic [31:0] w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
  logic [5:0]  w_rd_base;

  assign w_req_len = key_len_e'(key_len);
  assign w_len_ok  = (w_req_len != KL_RSV) &&
                     ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
  assign w_nk      = nk_of(r_key_len);
  assign w_nk_req  = nk_of(w_req_len);

  assign w_prev   = r_w[r_i - 6'd1];
  assign w_back   = r_w[r_i - {2'b00, w_nk}];
  assign w_sub_in = (r_k == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  // One S-box bank serves both the rotated and the plain SubWord paths.
  aes_sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_k == 3'd0)
      w_temp = w_sub_out ^ {r_rcon, 24'h0};
    else if (w_nk == 4'd8 && r_k == 3'd4)
      w_temp = w_sub_out;
  end

  assign w_new = w_back ^ w_temp;

  always_comb begin
    w_state_nxt      = r_state;
    w_i_nxt          = r_i;
    w_k_nxt          = r_k;
    w_rcon_nxt       = r_rcon;
    w_key_len_nxt    = r_key_len;
    w_nr_nxt         = r_nr;
    w_keys_valid_nxt = r_keys_valid;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_load           = 1'b0;
    w_wr             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!w_len_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load           = 1'b1;
            w_key_len_nxt    = w_req_len;
            w_nr_nxt         = nr_of(w_req_len);
            w_keys_valid_nxt = 1'b0;
            w_i_nxt          = {2'b00, w_nk_req};
            w_k_nxt          = 3'd0;
            w_rcon_nxt       = 8'h01;
            w_state_nxt      = ST_EXPAND;
          end
        end
      end
      ST_EXPAND: begin
        w_wr    = 1'b1;
        w_i_nxt = r_i + 6'd1;
        w_k_nxt = ({1'b0, r_k} == w_nk - 4'd1) ? 3'd0 : r_k + 3'd1;
        if (r_k == 3'd0)
          w_rcon_nxt = xtime(r_rcon);
        // Last word index is 4*(Nr+1)-1 = {Nr, 2'b11}.
        if (r_i == {r_nr, 2'b11}) begin
          w_state_nxt      = ST_IDLE;
          w_done_nxt       = 1'b1;
          w_keys_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_i          <= 6'd0;
      r_k          <= 3'd0;
      r_rcon       <= 8'h01;
      r_key_len    <= KL_128;
      r_nr         <= 4'd10;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_i          <= w_i_nxt;
      r_k          <= w_k_nxt;
      r_rcon       <= w_rcon_nxt;
      r_key_len    <= w_key_len_nxt;
      r_nr         <= w_nr_nxt;
      r_keys_valid <= w_keys_valid_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Word store carries no reset; validity is tracked by keys_valid.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int j = 0; j < 8; j++) begin
        if (j < int'(w_nk_req) && j < NWORDS)
          r_w[j] <= key[255 - 32*j -: 32];
      end
    end else if (w_wr) begin
      r_w[r_i] <= w_new;
    end
  end

  assign w_rd_base = {rd_round, 2'b00};

  always_comb begin
    rd_key = '0;
    if (rd_round <= r_nr && (int'(w_rd_base) + 3) < NWORDS)
      rd_key = {r_w[w_rd_base],         r_w[w_rd_base + 6'd1],
                r_w[w_rd_base + 6'd2],  r_w[w_rd_base + 6'd3]};
  end

  assign ready      = (r_state == ST_IDLE);
  assign done       = r_done;
  assign keys_valid = r_keys_valid;
  assign err        = r_err;
  assign nr         = r_nr;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key-expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_len = 2'd0;
  logic [255:0] key = '0;
  logic         ready, done, keys_valid, err;
  logic [3:0]   nr;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;

  logic         start2 = 1'b0;
  logic [1:0]   key_len2 = 2'd0;
  logic         ready2, done2, keys_valid2, err2;
  logic [3:0]   nr2;
  logic [127:0] rd_key2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .ready(ready), .done(done), .keys_valid(keys_valid), .err(err), .nr(nr),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start2), .key_len(key_len2), .key(key),
    .ready(ready2), .done(done2), .keys_valid(keys_valid2), .err(err2), .nr(nr2),
    .rd_round(4'd0), .rd_key(rd_key2)
  );

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           cyc;
    logic [3:0]   nr;
    logic [3:0]   ra;
    logic [127:0] ea;
    logic [3:0]   rb;
    logic [127:0] eb;
  } vec_t;

  vec_t vecs [3];

  localparam logic [255:0] K128 =
    256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K192 =
    256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b_0000000000000000;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launches an expansion and returns the number of edges from acceptance to done.
  // A nonzero mid pulses start during EXPAND at that cycle.
  task automatic run_expand(input logic [1:0] kl, input logic [255:0] k,
                            input int mid, output int cyc, output int errs);
    @(negedge clk);
    key_len = kl; key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; errs = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (err) errs++;
      if (done) break;
      if (cyc == 5) check("ready_low_in_expand", 128'(ready), 128'(1'b0));
      if (mid != 0 && cyc == mid) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    if (cyc >= 200) check("done_timeout", 128'(done), 128'(1'b1));
  endtask

  task automatic read_round(input logic [3:0] r, input string name, input logic [127:0] exp);
    rd_round = r;
    #1;
    check(name, rd_key, exp);
  endtask

  int cyc, errs;

  initial begin
    vecs[0] = '{2'd0, K128, 40, 4'd10,
                4'd1,  128'ha0fafe1788542cb123a339392a6c7605,
                4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{2'd1, K192, 46, 4'd12,
                4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5,
                4'd12, 128'he98ba06f448c773c8ecc720401002202};
    vecs[2] = '{2'd2, K256, 52, 4'd14,
                4'd1,  128'h1f352c073b6108d72d9810a30914dff4,
                4'd14, 128'hfe4890d1e6188d0b046df344706c631e};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(ready), 128'(1'b1));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_keys_valid", 128'(keys_valid), 128'(1'b0));
    check("rst_err", 128'(err), 128'(1'b0));
    check("rst_nr", 128'(nr), 128'(4'd10));
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      run_expand(vecs[v].kl, vecs[v].key, 0, cyc, errs);
      check($sformatf("v%0d_done_cycles", v), 128'(cyc), 128'(vecs[v].cyc));
      check($sformatf("v%0d_nr", v), 128'(nr), 128'(vecs[v].nr));
      check($sformatf("v%0d_keys_valid", v), 128'(keys_valid), 128'(1'b1));
      check($sformatf("v%0d_ready", v), 128'(ready), 128'(1'b1));
      read_round(vecs[v].ra, $sformatf("v%0d_round%0d", v, vecs[v].ra), vecs[v].ea);
      read_round(vecs[v].rb, $sformatf("v%0d_round%0d", v, vecs[v].rb), vecs[v].eb);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse_end", v), 128'(done), 128'(1'b0));
    end

    // Reserved key length with a valid 256-bit schedule held.
    @(negedge clk);
    key_len = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    check("rsv_err", 128'(err), 128'(1'b1));
    check("rsv_ready", 128'(ready), 128'(1'b1));
    check("rsv_done", 128'(done), 128'(1'b0));
    check("rsv_keys_valid", 128'(keys_valid), 128'(1'b1));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("rsv_err_pulse_end", 128'(err), 128'(1'b0));
    check("rsv_nr_kept", 128'(nr), 128'(4'd14));

    // 256-bit request on a 128-bit-limited instance.
    @(negedge clk);
    key_len2 = 2'd2; start2 = 1'b1;
    @(posedge clk); #1;
    check("max128_err", 128'(err2), 128'(1'b1));
    check("max128_ready", 128'(ready2), 128'(1'b1));
    @(negedge clk);
    start2 = 1'b0;
    @(posedge clk); #1;
    check("max128_err_pulse_end", 128'(err2), 128'(1'b0));
    check("max128_keys_valid", 128'(keys_valid2), 128'(1'b0));

    // start pulsed mid-expansion must be ignored.
    run_expand(2'd0, K128, 10, cyc, errs);
    check("mid_start_done_cycles", 128'(cyc), 128'(40));
    check("mid_start_no_err", 128'(errs), 128'(0));
    read_round(4'd10, "mid_start_round10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_round(4'd11, "rd_out_of_range", 128'h0);
    read_round(4'd15, "rd_out_of_range15", 128'h0);

    // Reset at cycle 20 of a 256-bit run.
    @(negedge clk);
    key_len = 2'd2; key = K256; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_ready_before", 128'(ready), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_keys_valid", 128'(keys_valid), 128'(1'b0));
    check("mid_rst_ready", 128'(ready), 128'(1'b1));
    check("mid_rst_nr", 128'(nr), 128'(4'd10));
    @(negedge clk);
    rst_n = 1'b1;

    run_expand(2'd0, K128, 0, cyc, errs);
    check("post_rst_done_cycles", 128'(cyc), 128'(40));
    check("post_rst_keys_valid", 128'(keys_valid), 128'(1'b1));
    read_round(4'd0, "post_rst_round0", 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_round(4'd1, "post_rst_round1", 128'ha0fafe1788542cb123a339392a6c7605);
    read_round(4'd10, "post_rst_round10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
